// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box tables, GF(2^8) helpers, state byte layout
// and the key-length to round-count mapping.
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int NBYTES  = 16;

  // Byte 0 of a block is the most significant byte, so element 15 of this
  // packed array holds byte 0.
  typedef logic [NBYTES-1:0][7:0] aes_block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } dec_state_e;

  // Element index of state byte (row, col); bytes fill the state column-major.
  function automatic int byte_pos(input int row, input int col);
    return NBYTES - 1 - (4 * col + row);
  endfunction

  // Rounds required for a given key length in 32-bit words.
  function automatic int nr_for_nk(input int nk);
    return nk + 6;
  endfunction

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Table entry b sits at bit offset 8*(255-b), which is {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return INV_SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    logic [7:0] m8;
    m8 = gf_mul2(gf_mul2(gf_mul2(a)));
    return m8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] a);
    logic [7:0] m2, m8;
    m2 = gf_mul2(a);
    m8 = gf_mul2(gf_mul2(m2));
    return m8 ^ m2 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] a);
    logic [7:0] m4, m8;
    m4 = gf_mul2(gf_mul2(a));
    m8 = gf_mul2(m4);
    return m8 ^ m4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] a);
    logic [7:0] m2, m4, m8;
    m2 = gf_mul2(a);
    m4 = gf_mul2(m2);
    m8 = gf_mul2(m4);
    return m8 ^ m4 ^ m2;
  endfunction

  // Round constant for key-expansion step j (j >= 1): x^(j-1) in GF(2^8).
  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < j; i++) r = gf_mul2(r);
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] st_o
);

  aes_block_t s_in, isr, ark, imc;

  // Inverse round datapath; the last round skips InvMixColumns.
  always_comb begin
    s_in = st_i;
    isr  = '0;
    imc  = '0;
    // Row r was rotated left by r on the encrypt side, so read from column c-r.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        isr[byte_pos(r, c)] = inv_sbox(s_in[byte_pos(r, (c - r + 4) % 4)]);
      end
    end
    ark = isr ^ rk_i;
    for (int c = 0; c < 4; c++) begin
      imc[byte_pos(0, c)] = gf_mul14(ark[byte_pos(0, c)]) ^ gf_mul11(ark[byte_pos(1, c)])
                          ^ gf_mul13(ark[byte_pos(2, c)]) ^ gf_mul9(ark[byte_pos(3, c)]);
      imc[byte_pos(1, c)] = gf_mul9(ark[byte_pos(0, c)])  ^ gf_mul14(ark[byte_pos(1, c)])
                          ^ gf_mul11(ark[byte_pos(2, c)]) ^ gf_mul13(ark[byte_pos(3, c)]);
      imc[byte_pos(2, c)] = gf_mul13(ark[byte_pos(0, c)]) ^ gf_mul9(ark[byte_pos(1, c)])
                          ^ gf_mul14(ark[byte_pos(2, c)]) ^ gf_mul11(ark[byte_pos(3, c)]);
      imc[byte_pos(3, c)] = gf_mul11(ark[byte_pos(0, c)]) ^ gf_mul13(ark[byte_pos(1, c)])
                          ^ gf_mul9(ark[byte_pos(2, c)])  ^ gf_mul14(ark[byte_pos(3, c)]);
    end
    st_o = last_i ? ark : imc;
  end

endmodule

// File: rtl/aes_key_expansion.sv
// Combinational AES key schedule. Round key r occupies w_o[r*128 +: 128],
// with its first word in the most significant 32 bits.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic [NK*32-1:0]      key_i,
  output logic [(NR+1)*128-1:0] w_o
);

  localparam int NW = 4 * (NR + 1);

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [NW*32-1:0] expand(input logic [NK*32-1:0] k);
    logic [31:0]      w [NW];
    logic [31:0]      t;
    logic [NW*32-1:0] flat;
    for (int i = 0; i < NK; i++) w[i] = k[(NK-1-i)*32 +: 32];
    for (int i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / NK), 24'h000000};
      else if (NK > 6 && i % NK == 4) t = sub_word(t);
      w[i] = w[i-NK] ^ t;
    end
    for (int i = 0; i < NW; i++) flat[(i/4)*128 + (3-(i%4))*32 +: 32] = w[i];
    return flat;
  endfunction

  assign w_o = expand(key_i);

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: accepts a ciphertext block and key, runs one
// inverse round per clock, and presents the plaintext on a ready/valid port.
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NK*32-1:0] key,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    ciphertext,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    plaintext,
  output logic            busy
);

  localparam int RND_W  = $clog2(NR + 1);
  localparam int KEXP_W = (NR + 1) * 128;
  localparam int KOFF_W = $clog2(KEXP_W);

  if (!(NK == 4 || NK == 6 || NK == 8) || NR != nr_for_nk(NK)) begin : g_bad_cfg
    $error("aes_decrypt_iter: NK=%0d needs NR=%0d, got NR=%0d", NK, nr_for_nk(NK), NR);
  end

  dec_state_e          state_q, state_d;
  logic [RND_W-1:0]    rnd_q, rnd_d;
  logic [NK*32-1:0]    key_q, key_d;
  logic [127:0]        st_q, st_d;
  logic [127:0]        pt_q, pt_d;
  logic [NK*32-1:0]    kexp_key;
  logic [KEXP_W-1:0]   kexp;
  logic [RND_W-1:0]    rk_sel;
  logic [KOFF_W-1:0]   rk_off;
  logic [127:0]        rk;
  logic [127:0]        round_out;
  logic                last;

  // While idle the schedule runs on the live key so w[NR] is ready at accept.
  assign kexp_key = (state_q == ST_IDLE) ? key : key_q;
  assign rk_sel   = (state_q == ST_IDLE) ? RND_W'(NR) : rnd_q;
  assign last     = (state_q == ST_FINAL);
  assign plaintext = pt_q;

  aes_key_expansion #(.NK(NK), .NR(NR)) u_kexp (
    .key_i (kexp_key),
    .w_o   (kexp)
  );

  // Select the current round key from the flat schedule bus.
  always_comb begin
    rk_off = KOFF_W'(rk_sel) << 7;
    rk     = kexp[rk_off +: 128];
  end

  aes_inv_round u_round (
    .st_i   (st_q),
    .rk_i   (rk),
    .last_i (last),
    .st_o   (round_out)
  );

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    key_d     = key_q;
    st_d      = st_q;
    pt_d      = pt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          key_d   = key;
          st_d    = ciphertext ^ rk;
          rnd_d   = RND_W'(NR - 1);
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        st_d  = round_out;
        rnd_d = rnd_q - RND_W'(1);
        if (rnd_q == RND_W'(1)) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        st_d    = round_out;
        pt_d    = round_out;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any block in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      key_q   <= '0;
      st_q    <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      key_q   <= key_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter covering AES-128/192/256 vectors,
// output back-pressure, back-to-back blocks and reset mid-operation.
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic         iv4, iv6, iv8, ir4, ir6, ir8, ov4, ov6, ov8, or4, or6, or8;
  logic         busy4, busy6, busy8;
  logic [127:0] ct4, ct6, ct8, pt4, pt6, pt8;

  logic [127:0] sb [$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int lat;

  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KB  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;

  aes_decrypt_iter #(.NK(4), .NR(10)) dut4 (
    .clk(clk), .reset(reset), .key(key4), .in_valid(iv4), .in_ready(ir4),
    .ciphertext(ct4), .out_valid(ov4), .out_ready(or4), .plaintext(pt4), .busy(busy4));
  aes_decrypt_iter #(.NK(6), .NR(12)) dut6 (
    .clk(clk), .reset(reset), .key(key6), .in_valid(iv6), .in_ready(ir6),
    .ciphertext(ct6), .out_valid(ov6), .out_ready(or6), .plaintext(pt6), .busy(busy6));
  aes_decrypt_iter #(.NK(8), .NR(14)) dut8 (
    .clk(clk), .reset(reset), .key(key8), .in_valid(iv8), .in_ready(ir8),
    .ciphertext(ct8), .out_valid(ov8), .out_ready(or8), .plaintext(pt8), .busy(busy8));

  // Key whose bytes are 00,01,02,... left-aligned in 256 bits.
  function automatic logic [255:0] seq_key(input int n);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[255-8*i -: 8] = 8'(i);
    return k;
  endfunction

  function automatic logic get_ov(input int sel);
    return (sel == 4) ? ov4 : (sel == 6) ? ov6 : ov8;
  endfunction
  function automatic logic get_ir(input int sel);
    return (sel == 4) ? ir4 : (sel == 6) ? ir6 : ir8;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 4) ? busy4 : (sel == 6) ? busy6 : busy8;
  endfunction
  function automatic logic [127:0] get_pt(input int sel);
    return (sel == 4) ? pt4 : (sel == 6) ? pt6 : pt8;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [127:0] ct, input logic [255:0] k);
    case (sel)
      4:       begin iv4 = v; ct4 = ct; key4 = k[255:128]; end
      6:       begin iv6 = v; ct6 = ct; key6 = k[255:64];  end
      default: begin iv8 = v; ct8 = ct; key8 = k;          end
    endcase
  endtask

  task automatic set_ordy(input int sel, input logic r);
    case (sel)
      4:       or4 = r;
      6:       or6 = r;
      default: or8 = r;
    endcase
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check(tag, 128'(obs), 128'(exp));
  endtask

  // Called 1 time unit after the accept edge; counts edges until out_valid.
  task automatic wait_valid(input int sel, output int n);
    n = 0;
    while (get_ov(sel) !== 1'b1 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic decrypt_one(input int sel, input string tag, input logic [127:0] ct,
                             input logic [255:0] k, input logic [127:0] pt, input int nr,
                             input bit hold);
    int l;
    @(negedge clk);
    chk1({tag, " in_ready"}, get_ir(sel), 1'b1);
    set_in(sel, 1'b1, ct, k);
    sb.push_back(pt);
    @(posedge clk);
    #1;
    set_in(sel, 1'b0, ~ct, ~k);
    wait_valid(sel, l);
    check({tag, " latency"}, 128'(l), 128'(nr));
    check({tag, " plaintext"}, get_pt(sel), sb.pop_front());
    if (!hold) begin
      set_ordy(sel, 1'b1);
      @(posedge clk);
      #1;
      set_ordy(sel, 1'b0);
      chk1({tag, " out_valid drop"}, get_ov(sel), 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_in(4, 1'b0, '0, '0);
    set_in(6, 1'b0, '0, '0);
    set_in(8, 1'b0, '0, '0);
    or4 = 1'b0; or6 = 1'b0; or8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state of all three configurations
    for (int s = 4; s <= 8; s += 2) begin
      chk1("reset in_ready", get_ir(s), 1'b1);
      chk1("reset out_valid", get_ov(s), 1'b0);
      chk1("reset busy", get_busy(s), 1'b0);
      check("reset plaintext", get_pt(s), 128'h0);
    end
    reset = 1'b0;

    // Known-answer vectors for the three key lengths
    decrypt_one(4, "aes128", CT1, seq_key(16), PT1, 10, 1'b0);
    decrypt_one(6, "aes192", CT2, seq_key(24), PT1, 12, 1'b0);
    decrypt_one(8, "aes256", CT3, seq_key(32), PT1, 14, 1'b0);
    decrypt_one(4, "fips128", CTB, KB, PTB, 10, 1'b0);

    // Back-pressure: output held, new input pulses ignored
    decrypt_one(4, "hold", CT1, seq_key(16), PT1, 10, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_in(4, i[0], CTB, KB);
      @(posedge clk);
      #1;
      chk1("hold out_valid", get_ov(4), 1'b1);
      check("hold plaintext", get_pt(4), PT1);
      chk1("hold in_ready", get_ir(4), 1'b0);
    end
    @(negedge clk);
    set_in(4, 1'b0, '0, '0);
    set_ordy(4, 1'b1);
    @(posedge clk);
    #1;
    set_ordy(4, 1'b0);
    chk1("hold release out_valid", get_ov(4), 1'b0);
    chk1("hold release in_ready", get_ir(4), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk1("hold no stray accept", get_busy(4), 1'b0);

    // Back-to-back with in_valid held high and out_ready high
    @(negedge clk);
    set_ordy(4, 1'b1);
    set_in(4, 1'b1, CT1, seq_key(16));
    sb.push_back(PT1);
    @(posedge clk);
    #1;
    set_in(4, 1'b1, CTB, KB);
    sb.push_back(PTB);
    wait_valid(4, lat);
    check("b2b first latency", 128'(lat), 128'(10));
    check("b2b first plaintext", get_pt(4), sb.pop_front());
    @(posedge clk);
    #1;
    chk1("b2b bubble in_ready", get_ir(4), 1'b1);
    chk1("b2b bubble out_valid", get_ov(4), 1'b0);
    @(posedge clk);
    #1;
    chk1("b2b second accepted", get_busy(4), 1'b1);
    set_in(4, 1'b0, '0, '0);
    wait_valid(4, lat);
    check("b2b second latency", 128'(lat), 128'(10));
    check("b2b second plaintext", get_pt(4), sb.pop_front());
    @(posedge clk);
    #1;
    set_ordy(4, 1'b0);
    chk1("b2b final out_valid", get_ov(4), 1'b0);

    // Reset in the middle of a block
    @(negedge clk);
    set_in(4, 1'b1, CT1, seq_key(16));
    @(posedge clk);
    #1;
    set_in(4, 1'b0, '0, '0);
    repeat (4) @(posedge clk);
    #1;
    chk1("midrun busy", get_busy(4), 1'b1);
    reset = 1'b1;
    #1;
    chk1("abort out_valid", get_ov(4), 1'b0);
    check("abort plaintext", get_pt(4), 128'h0);
    chk1("abort in_ready", get_ir(4), 1'b1);
    chk1("abort busy", get_busy(4), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk1("abort no emission", get_ov(4), 1'b0);
    decrypt_one(4, "post-reset", CTB, KB, PTB, 10, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
